// File: rtl/rv32_apx_pkg.sv
// Shared types and defaults for the PC fetch sequencer slice.
package rv32_apx_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundles the imem fetch handshake and the execute datapath handshake.
// The master side is the sequencer; the slave side is imem plus datapath.
interface pc_fetch_sequencer_if
  import rv32_apx_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            exec_done;
  logic            branch;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] imm;
  logic            halt_req;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, exec_done, branch, result, imm, halt_req
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, exec_done, branch, result, imm, halt_req
  );

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: branch target pc+imm when taken, else pc+1.
// Word-addressed, wraps modulo 2^XLEN; imm is two's complement.
module pc_next_calc
  import rv32_apx_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            taken,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect
);

  // select branch target or sequential successor
  always_comb begin
    next_pc  = taken ? (pc + imm) : (pc + XLEN'(1));
    redirect = taken;
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner: fetch from imem, hand off to execute, then
// commit the next PC. All outputs come straight from flops.
//
// state  | meaning
// IDLE   | parked, waiting for run
// FETCH  | imem_req high at imem_addr=pc, waiting for imem_ack
// EXEC   | instr handed off, waiting for exec_done
// UPDATE | commit next PC, count retirement, choose next state
// HALT   | halted high, PC frozen until reset
module pc_fetch_sequencer
  import rv32_apx_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  pc_fetch_sequencer_if.master bus,
  output logic [XLEN-1:0]      pc,
  output logic                 redirect,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  next_pc_q, next_pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic             req_q, req_d;
  logic             ivalid_q, ivalid_d;
  logic             redir_q, redir_d;
  logic             halted_q, halted_d;
  logic             halt_lat_q, halt_lat_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic             taken_now;
  logic [XLEN-1:0]  calc_next_pc;
  logic             calc_redirect;

  // The branch outcome is resolved at exec_done; the resulting target is
  // captured then so that UPDATE only has to commit it. Capturing the sum
  // is equivalent to capturing taken/imm because pc cannot move in EXEC,
  // and it lets redirect be a flop that is high during UPDATE itself.
  assign taken_now = bus.branch && (bus.result == '0);

  pc_next_calc #(.XLEN(XLEN)) u_pc_next_calc (
    .pc       (pc_q),
    .imm      (bus.imm),
    .taken    (taken_now),
    .next_pc  (calc_next_pc),
    .redirect (calc_redirect)
  );

  // state and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      next_pc_q  <= RESET_PC;
      instr_q    <= '0;
      req_q      <= 1'b0;
      ivalid_q   <= 1'b0;
      redir_q    <= 1'b0;
      halted_q   <= 1'b0;
      halt_lat_q <= 1'b0;
      ret_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      next_pc_q  <= next_pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      ivalid_q   <= ivalid_d;
      redir_q    <= redir_d;
      halted_q   <= halted_d;
      halt_lat_q <= halt_lat_d;
      ret_q      <= ret_d;
    end
  end

  // next state and next values of the output flops (pulses default low)
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    next_pc_d  = next_pc_q;
    instr_d    = instr_q;
    req_d      = 1'b0;
    ivalid_d   = 1'b0;
    redir_d    = 1'b0;
    halted_d   = 1'b0;
    halt_lat_d = halt_lat_q;
    ret_d      = ret_q;

    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end
      end
      ST_FETCH: begin
        req_d = 1'b1;
        if (bus.imem_ack) begin
          instr_d  = bus.imem_rdata;
          req_d    = 1'b0;
          ivalid_d = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.exec_done) begin
          next_pc_d  = calc_next_pc;
          redir_d    = calc_redirect;
          halt_lat_d = bus.halt_req;
          state_d    = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        pc_d  = next_pc_q;
        ret_d = (ret_q == '1) ? ret_q : ret_q + CNT_W'(1);
        if (halt_lat_q) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (run) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = ivalid_q;
  assign pc              = pc_q;
  assign redirect        = redir_q;
  assign halted          = halted_q;
  assign retired         = ret_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed vector table,
// hand-written corner sequences and a randomized run against a
// transaction-level PC model.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [31:0] pc;
  logic        redirect;
  logic        halted;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_pc;
  logic [31:0] model_retired;

  pc_fetch_sequencer_if #(.XLEN(32)) bus ();

  pc_fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .bus      (bus),
    .pc       (pc),
    .redirect (redirect),
    .halted   (halted),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ack_wait;
    int          done_wait;
    logic        br;
    logic [31:0] res;
    logic [31:0] imm;
    logic [31:0] exp_addr;
    logic        exp_redir;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One instruction from a FETCH negedge to the negedge after UPDATE.
  // The fixed negedge schedule also checks the 3 + waits cadence.
  task automatic do_instr(input logic [31:0] exp_addr, input int ack_wait,
                          input int done_wait, input logic br,
                          input logic [31:0] res, input logic [31:0] im,
                          input logic hr, input logic run_after,
                          input logic exp_redir, input logic [31:0] exp_next);
    logic [31:0] word;
    word = $urandom;
    chk("fetch_req", {31'b0, bus.imem_req}, 32'd1);
    chk("fetch_addr", bus.imem_addr, exp_addr);
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge clk);
      chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
      chk("no_early_valid", {31'b0, bus.instr_valid}, 32'd0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    run            = run_after;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    chk("instr_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("instr_word", bus.instr, word);
    chk("req_drop", {31'b0, bus.imem_req}, 32'd0);
    for (int i = 0; i < done_wait; i++) begin
      bus.imem_ack = 1'b1;
      @(negedge clk);
      chk("valid_single", {31'b0, bus.instr_valid}, 32'd0);
      chk("no_refetch", {31'b0, bus.imem_req}, 32'd0);
    end
    bus.imem_ack  = 1'b0;
    bus.exec_done = 1'b1;
    bus.branch    = br;
    bus.result    = res;
    bus.imm       = im;
    bus.halt_req  = hr;
    @(negedge clk);
    bus.exec_done = 1'b0;
    bus.branch    = 1'($urandom);
    bus.result    = $urandom;
    bus.imm       = $urandom;
    bus.halt_req  = 1'b0;
    chk("redirect", {31'b0, redirect}, {31'b0, exp_redir});
    chk("update_no_valid", {31'b0, bus.instr_valid}, 32'd0);
    @(negedge clk);
    model_retired = model_retired + 32'd1;
    chk("next_pc", pc, exp_next);
    chk("retired", retired, model_retired);
    chk("halted", {31'b0, halted}, {31'b0, hr});
    chk("redirect_pulse", {31'b0, redirect}, 32'd0);
    chk("req_after", {31'b0, bus.imem_req}, {31'b0, run_after && !hr});
  endtask

  initial begin
    logic        br, taken, run_after;
    logic [31:0] res, im, nxt;
    int          aw, dw, gap;

    vecs[0] = '{0, 0, 1'b0, 32'd0, 32'd0,         32'd0, 1'b0, 32'd1};
    vecs[1] = '{0, 0, 1'b0, 32'd3, 32'd9,         32'd1, 1'b0, 32'd2};
    vecs[2] = '{0, 0, 1'b0, 32'd0, 32'd4,         32'd2, 1'b0, 32'd3};
    vecs[3] = '{0, 0, 1'b0, 32'd1, 32'd1,         32'd3, 1'b0, 32'd4};
    vecs[4] = '{1, 0, 1'b0, 32'd0, 32'd0,         32'd4, 1'b0, 32'd5};
    vecs[5] = '{0, 0, 1'b1, 32'd0, 32'hFFFF_FFFE, 32'd5, 1'b1, 32'd3};
    vecs[6] = '{0, 1, 1'b0, 32'd0, 32'd2,         32'd3, 1'b0, 32'd4};
    vecs[7] = '{2, 0, 1'b0, 32'd0, 32'd0,         32'd4, 1'b0, 32'd5};
    vecs[8] = '{0, 0, 1'b1, 32'd7, 32'd10,        32'd5, 1'b0, 32'd6};
    vecs[9] = '{5, 3, 1'b0, 32'd0, 32'd0,         32'd6, 1'b0, 32'd7};

    reset          = 1'b1;
    run            = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.exec_done  = 1'b0;
    bus.branch     = 1'b0;
    bus.result     = '0;
    bus.imm        = '0;
    bus.halt_req   = 1'b0;
    model_retired  = '0;

    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_redirect", {31'b0, redirect}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_run", {31'b0, bus.imem_req}, 32'd0);
    run = 1'b1;
    @(negedge clk);

    // directed vector table from reset
    for (int v = 0; v < 10; v++) begin
      do_instr(vecs[v].exp_addr, vecs[v].ack_wait, vecs[v].done_wait,
               vecs[v].br, vecs[v].res, vecs[v].imm, 1'b0, 1'b1,
               vecs[v].exp_redir, vecs[v].exp_next);
    end
    chk("retired_table", retired, 32'd10);

    // jump to the top of the address space, then wrap sequentially to 0
    do_instr(32'd7, 0, 0, 1'b1, 32'd0, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    do_instr(32'hFFFF_FFFF, 0, 1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    model_pc = 32'd0;

    // randomized instructions against the PC model
    for (int k = 0; k < 40; k++) begin
      aw        = int'($urandom_range(0, 3));
      dw        = int'($urandom_range(0, 3));
      br        = 1'($urandom_range(0, 1));
      res       = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
      im        = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom_range(0, 16) - 32'd8);
      run_after = ($urandom_range(0, 3) != 0);
      taken     = br && (res == 32'd0);
      nxt       = taken ? model_pc + im : model_pc + 32'd1;
      do_instr(model_pc, aw, dw, br, res, im, 1'b0, run_after, taken, nxt);
      model_pc = nxt;
      if (!run_after) begin
        gap = int'($urandom_range(1, 3));
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("idle_req", {31'b0, bus.imem_req}, 32'd0);
          chk("idle_pc", pc, model_pc);
        end
        run = 1'b1;
        @(negedge clk);
      end
    end

    // halt takes priority over run
    do_instr(model_pc, 0, 0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, model_pc + 32'd1);
    for (int h = 0; h < 20; h++) begin
      @(negedge clk);
      chk("halt_req_low", {31'b0, bus.imem_req}, 32'd0);
      chk("halt_hold", {31'b0, halted}, 32'd1);
      chk("halt_pc", pc, model_pc + 32'd1);
    end

    // async reset out of HALT
    reset = 1'b1;
    #1;
    chk("rst_halt_drop", {31'b0, halted}, 32'd0);
    chk("rst_halt_pc", pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b1;
    @(negedge clk);
    chk("refetch_req", {31'b0, bus.imem_req}, 32'd1);

    // async reset mid-FETCH, between clock edges
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_mid_pc", pc, 32'd0);
    chk("rst_mid_retired", retired, 32'd0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", {31'b0, bus.imem_req}, 32'd0);
      chk("post_rst_pc", pc, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Clocked controller that owns the program counter and sequences each instruction through fetch, execute and PC update. Replaces free-running step-driven PC increment with an explicit FSM:
- Handshakes with instruction memory (req/ack) and the execute datapath (valid/done).
- Resolves branches: taken when branch && result==0, target = current PC + immediate.
- Sits between imem and the decode/ALU datapath; PC is word-addressed (sequential next = pc+1).

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 0, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset: asynchronous, active-high
run  input  1  level; enables sequencing out of IDLE
imem_ack  input  1  imem has valid data on imem_rdata this cycle
imem_rdata  input  XLEN  fetched instruction word
exec_done  input  1  datapath finished current instruction; branch/result/imm valid this cycle
branch  input  1  current instruction is a conditional branch
result  input  XLEN  ALU result; branch taken iff result==0
imm  input  XLEN  sign-extended immediate (word offset)
halt_req  input  1  current instruction requests halt (sampled with exec_done)
pc  output  XLEN  architectural PC of the instruction in flight
imem_req  output  1  fetch request, registered
imem_addr  output  XLEN  equals pc while imem_req=1
instr  output  XLEN  latched instruction word
instr_valid  output  1  one-cycle pulse: instr is valid, start execute
redirect  output  1  one-cycle pulse in UPDATE when branch taken
halted  output  1  high while in HALT
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset (async, any state, mid-handshake included):
  - state=IDLE, pc=RESET_PC.
  - imem_req, instr_valid, redirect and halted all drop immediately.
  - instr=0, retired=0.
- States: IDLE, FETCH, EXEC, UPDATE, HALT. All outputs are registered.
- IDLE:
  - run=1 -> FETCH next cycle with imem_req=1.
  - run=0 -> stay.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ack=1: latch instr<=imem_rdata, imem_req<=0, instr_valid<=1 (pulse), -> EXEC.
  - No ack: hold. Waiting is unbounded.
  - imem_ack while not in FETCH: ignored.
- EXEC:
  - Wait for exec_done. On exec_done, latch taken=(branch && result==0), imm and halt_req, then -> UPDATE.
  - exec_done may arrive in the cycle immediately after the instr_valid pulse, so minimum EXEC is 1 cycle.
- UPDATE (exactly 1 cycle):
  - Taken: pc<=pc+imm (mod 2^XLEN), redirect=1.
  - Otherwise: pc<=pc+1 (mod 2^XLEN).
  - retired<=retired+1, saturating at all-ones.
  - Next state: halt_req latched -> HALT; else run=1 -> FETCH (imem_req=1 next cycle); else IDLE.
- HALT: halted=1, pc holds the updated value. Exit only via reset.
- Minimum instruction latency: fetch issue to next fetch issue = 3 cycles with zero-wait ack and done (FETCH, EXEC, UPDATE).
- Wrap-around: pc=0xFFFFFFFF non-taken -> 0. Negative imm handled as two's complement.
- branch=1 with result!=0: not taken, redirect stays 0.
- run deassert:
  - Honoured only in IDLE/UPDATE. An in-flight instruction always completes.
  - halt_req takes priority over run.

Decomposition:
- Shared package rv32_apx_pkg:
  - state enum (IDLE, FETCH, EXEC, UPDATE, HALT).
  - XLEN constant.
  - RESET_PC default.
- One sub-module, pc_next_calc (combinational):
  - Inputs: pc, imm, taken.
  - Outputs: next_pc, redirect.
  - Kept separate so it is unit-testable.

Test Plan:
- Reset mid-FETCH (imem_req=1, no ack) -> imem_req=0 same cycle; after release pc=0, state IDLE.
- run=1, zero-wait ack/done, 4 non-branch instrs -> imem_addr sequence 0,1,2,3; fetch requests every 3 cycles; retired=4.
- At pc=5: branch=1, result=0, imm=0xFFFFFFFE -> redirect pulse, next imem_addr=3.
- At pc=5: branch=1, result=7, imm=10 -> no redirect, next imem_addr=6.
- imem_ack delayed 5 cycles and exec_done delayed 3 cycles -> instr_valid is a single pulse, no extra fetch, retired increments by exactly 1.
- pc=0xFFFFFFFF non-branch -> next pc=0.
- halt_req with run=1 -> halted=1, imem_req stays 0 for 20 cycles, pc=old+1.
